pipe_stage_reg: RTL and testbench
=================================

Name: pipe_stage_reg

Overview:
Generic parametrised pipeline stage register. It replaces the hand-written per-stage latches between pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries a datapath payload and a control-field payload, both qualified by a valid bit, under a ready/valid handshake.
- Supports an optional 2-entry skid buffer, synchronous flush, and bubble-safe control zeroing.
- Saturating stall and bubble counters feed the performance monitor.

Parameters:
DATA_W, 128, width of datapath payload (PC+4, instruction, operands, immediate, dest reg).
CTRL_W, 16, width of control payload (RegW, MemR, MemW, Mem2R, ALU ctrl, ...); forced to 0 whenever the stage holds no valid beat.
SKID, 1, 1 = two-entry skid buffer with registered in_ready; 0 = single entry with combinational in_ready.
CNT_W, 16, width of the performance counters.

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
in_valid  in  1  upstream beat valid
in_ready  out  1  stage can accept a beat
in_data  in  DATA_W  upstream datapath payload
in_ctrl  in  CTRL_W  upstream control payload
out_valid  out  1  stage holds a valid beat
out_ready  in  1  downstream accepts
out_data  out  DATA_W  datapath payload of head entry
out_ctrl  out  CTRL_W  control payload of head entry; 0 when out_valid=0
flush  in  1  synchronous kill of all held beats
cnt_clr  in  1  synchronous clear of both counters
stall_cnt  out  CNT_W  cycles with out_valid & !out_ready
bubble_cnt  out  CNT_W  cycles with out_ready & !out_valid

Behaviour:
- Reset (async, rst=1):
  - All valid bits = 0; data and ctrl registers = 0.
  - out_valid = 0, out_ctrl = 0, out_data = 0.
  - in_ready = 1; stall_cnt = bubble_cnt = 0.
  - Reset mid-transfer discards every beat.
- Handshake: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready. Latency in→out is 1 cycle when the stage is empty.
- Storage: main entry M (valid, data, ctrl); when SKID=1, also skid entry S.
- Outputs: out_valid = M.valid; out_data = M.data; out_ctrl = M.valid ? M.ctrl : 0. Control zeroing makes an empty stage a bubble.
- Empty-stage data: when M empties, M.data keeps its last value and only M.valid/M.ctrl clear. out_data is don't-care while out_valid=0.
- SKID=0:
  - in_ready = out_ready | !M.valid (combinational).
  - On in_fire, M loads the input and M.valid=1.
  - On out_fire without in_fire, M.valid=0.
- SKID=1:
  - in_ready = !S.valid (registered, no combinational path from out_ready).
  - If out_fire or !M.valid: M loads S when S.valid, else loads the input on in_fire, else M.valid=0. If M loads S and in_fire, S loads the input; otherwise S.valid=0.
  - If M is held (M.valid & !out_ready) and in_fire: S loads the input and S.valid=1.
  - Full (S.valid=1): in_ready=0. Never overwrite a valid S.
- Ordering: strict FIFO order. Each accepted beat appears on the output exactly once: no drops, no duplicates, except under flush.
- Flush (priority below rst, above all else):
  - Next cycle M.valid = S.valid = 0, ctrl registers = 0, in_ready = 1.
  - An in_fire in the flush cycle is discarded.
  - An out_fire in the flush cycle completes normally; downstream keeps that beat.
- Counters:
  - Each counter increments by 1 per qualifying cycle and saturates at all-ones (no wrap).
  - cnt_clr forces 0 and wins over an increment in the same cycle.
  - Counters are not affected by flush.
- Simultaneous in_fire and out_fire with SKID=1 and only M valid: M takes the input, S stays empty (full throughput, 1 beat/cycle).

Test Plan:
- Reset: assert rst asynchronously mid-cycle with M and S valid → out_valid=0, out_ctrl=0, in_ready=1, counters=0 immediately, no clk edge needed.
- Streaming, SKID=1: out_ready=1, feed data 1..8 with in_valid=1 every cycle → out_data 1..8 on consecutive cycles starting 1 cycle later; bubble_cnt=1 (first cycle), stall_cnt=0.
- Back-pressure: out_ready=0 while sending A, B, C → A held in M, B in S, in_ready=0 from the cycle after B, C stalls upstream. Release out_ready → output A, B, C in order; stall_cnt counts the held cycles exactly.
- Flush: M=A, S=B valid, flush=1 with in_fire of C and out_ready=0 → next cycle out_valid=0, out_ctrl=0, in_ready=1. A, B and C never appear on the output.
- Bubble control: ctrl=16'hFFFF beat consumed, no new input → out_valid=0 and out_ctrl=16'h0000 while out_data retains the last value.
- Saturation: CNT_W=4, hold out_valid=1, out_ready=0 for 20 cycles → stall_cnt stops at 15. cnt_clr together with the increment condition → 0.
- Repeat the streaming and back-pressure scenarios with SKID=0: in_ready follows out_ready combinationally, same output order.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// Generic pipeline stage register: ready/valid handshake, optional 2-entry skid buffer,
// synchronous flush, control zeroing for bubbles, saturating stall/bubble counters.
module pipe_stage_reg #(
    parameter int unsigned DATA_W = 128,
    parameter int unsigned CTRL_W = 16,
    parameter int unsigned SKID   = 1,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    input  logic              flush,
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic              m_valid_q, m_valid_d;
    logic [DATA_W-1:0] m_data_q,  m_data_d;
    logic [CTRL_W-1:0] m_ctrl_q,  m_ctrl_d;
    logic              s_valid_q, s_valid_d;
    logic [DATA_W-1:0] s_data_q,  s_data_d;
    logic [CTRL_W-1:0] s_ctrl_q,  s_ctrl_d;
    logic [CNT_W-1:0]  stall_cnt_q,  stall_cnt_d;
    logic [CNT_W-1:0]  bubble_cnt_q, bubble_cnt_d;

    logic in_fire;
    logic out_fire;

    // With a skid entry, in_ready depends only on stored state; otherwise it looks through to out_ready
    assign in_ready  = (SKID != 0) ? !s_valid_q : (out_ready || !m_valid_q);
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = m_valid_q && out_ready;

    assign out_valid  = m_valid_q;
    assign out_data   = m_data_q;
    assign out_ctrl   = m_valid_q ? m_ctrl_q : '0;
    assign stall_cnt  = stall_cnt_q;
    assign bubble_cnt = bubble_cnt_q;

    // Entry update: M refills from S first, then from the input; S only catches beats while M is held
    always_comb begin
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        m_ctrl_d  = m_ctrl_q;
        s_valid_d = s_valid_q;
        s_data_d  = s_data_q;
        s_ctrl_d  = s_ctrl_q;

        if (flush) begin
            m_valid_d = 1'b0;
            m_ctrl_d  = '0;
            s_valid_d = 1'b0;
            s_ctrl_d  = '0;
        end else if (out_fire || !m_valid_q) begin
            if (s_valid_q) begin
                m_valid_d = 1'b1;
                m_data_d  = s_data_q;
                m_ctrl_d  = s_ctrl_q;
                if (in_fire) begin
                    s_data_d = in_data;
                    s_ctrl_d = in_ctrl;
                end else begin
                    s_valid_d = 1'b0;
                    s_ctrl_d  = '0;
                end
            end else if (in_fire) begin
                m_valid_d = 1'b1;
                m_data_d  = in_data;
                m_ctrl_d  = in_ctrl;
            end else begin
                m_valid_d = 1'b0;
                m_ctrl_d  = '0;
            end
        end else if (in_fire) begin
            s_valid_d = 1'b1;
            s_data_d  = in_data;
            s_ctrl_d  = in_ctrl;
        end

        if (SKID == 0) begin
            s_valid_d = 1'b0;
        end
    end

    // Saturating performance counters; clear wins over increment
    always_comb begin
        stall_cnt_d  = stall_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        if (cnt_clr) begin
            stall_cnt_d  = '0;
            bubble_cnt_d = '0;
        end else begin
            if (m_valid_q && !out_ready && (stall_cnt_q != CNT_MAX)) begin
                stall_cnt_d = stall_cnt_q + CNT_ONE;
            end
            if (out_ready && !m_valid_q && (bubble_cnt_q != CNT_MAX)) begin
                bubble_cnt_d = bubble_cnt_q + CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid_q    <= 1'b0;
            m_data_q     <= '0;
            m_ctrl_q     <= '0;
            s_valid_q    <= 1'b0;
            s_data_q     <= '0;
            s_ctrl_q     <= '0;
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            m_valid_q    <= m_valid_d;
            m_data_q     <= m_data_d;
            m_ctrl_q     <= m_ctrl_d;
            s_valid_q    <= s_valid_d;
            s_data_q     <= s_data_d;
            s_ctrl_q     <= s_ctrl_d;
            stall_cnt_q  <= stall_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: one skid instance (4-bit counters) and one
// single-entry instance share stimulus; each keeps its own FIFO reference model.
module tb_pipe_stage_reg;

    localparam int unsigned DW = 32;
    localparam int unsigned CWD = 16;

    typedef struct packed {
        logic [DW-1:0]  d;
        logic [CWD-1:0] c;
    } beat_t;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid;
    logic [DW-1:0]  in_data;
    logic [CWD-1:0] in_ctrl;
    logic           out_ready;
    logic           flush;
    logic           cnt_clr;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    for (genvar k = 0; k < 2; k++) begin : g_dut
        localparam int unsigned SK = (k == 0) ? 1 : 0;
        localparam int unsigned CW = (k == 0) ? 4 : 16;

        logic           in_ready;
        logic           out_valid;
        logic [DW-1:0]  out_data;
        logic [CWD-1:0] out_ctrl;
        logic [CW-1:0]  stall_cnt;
        logic [CW-1:0]  bubble_cnt;

        pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CWD), .SKID(SK), .CNT_W(CW)) u_dut (
            .clk        (clk),
            .rst        (rst),
            .in_valid   (in_valid),
            .in_ready   (in_ready),
            .in_data    (in_data),
            .in_ctrl    (in_ctrl),
            .out_valid  (out_valid),
            .out_ready  (out_ready),
            .out_data   (out_data),
            .out_ctrl   (out_ctrl),
            .flush      (flush),
            .cnt_clr    (cnt_clr),
            .stall_cnt  (stall_cnt),
            .bubble_cnt (bubble_cnt)
        );

        beat_t       q[$];
        int unsigned st, bb, cmax, cap;
        logic [DW-1:0] last_d;
        logic        exp_v, exp_rdy, of, inf;

        initial begin
            cmax = (1 << CW) - 1;
            cap  = (SK != 0) ? 2 : 1;
        end

        // Monitor/scoreboard: compare at negedge, then advance the model to the next edge
        always @(negedge clk) begin
            if (rst) begin
                chk($sformatf("rst_out_valid[%0d]", k), 64'(out_valid), 64'(0));
                chk($sformatf("rst_out_ctrl[%0d]", k), 64'(out_ctrl), 64'(0));
                chk($sformatf("rst_out_data[%0d]", k), 64'(out_data), 64'(0));
                chk($sformatf("rst_in_ready[%0d]", k), 64'(in_ready), 64'(1));
                chk($sformatf("rst_stall[%0d]", k), 64'(stall_cnt), 64'(0));
                chk($sformatf("rst_bubble[%0d]", k), 64'(bubble_cnt), 64'(0));
                q.delete();
                st = 0;
                bb = 0;
                last_d = '0;
            end else begin
                exp_v   = (q.size() > 0);
                exp_rdy = (SK != 0) ? (q.size() < cap) : (out_ready || q.size() == 0);
                chk($sformatf("out_valid[%0d]", k), 64'(out_valid), 64'(exp_v));
                chk($sformatf("in_ready[%0d]", k), 64'(in_ready), 64'(exp_rdy));
                chk($sformatf("stall_cnt[%0d]", k), 64'(stall_cnt), 64'(st));
                chk($sformatf("bubble_cnt[%0d]", k), 64'(bubble_cnt), 64'(bb));
                if (exp_v) begin
                    chk($sformatf("out_data[%0d]", k), 64'(out_data), 64'(q[0].d));
                    chk($sformatf("out_ctrl[%0d]", k), 64'(out_ctrl), 64'(q[0].c));
                    last_d = q[0].d;
                end else begin
                    chk($sformatf("bubble_ctrl[%0d]", k), 64'(out_ctrl), 64'(0));
                    chk($sformatf("held_data[%0d]", k), 64'(out_data), 64'(last_d));
                end

                of  = exp_v && out_ready;
                inf = in_valid && exp_rdy;
                if (of) void'(q.pop_front());
                if (flush) q.delete();
                else if (inf) q.push_back('{d: in_data, c: in_ctrl});

                if (cnt_clr) begin
                    st = 0;
                    bb = 0;
                end else begin
                    if (exp_v && !out_ready && st < cmax) st++;
                    if (out_ready && !exp_v && bb < cmax) bb++;
                end
            end
        end
    end

    task automatic drive(input logic iv, input logic [DW-1:0] d, input logic [CWD-1:0] c,
                         input logic ordy, input logic fl, input logic clr);
        @(posedge clk);
        #1;
        in_valid  = iv;
        in_data   = d;
        in_ctrl   = c;
        out_ready = ordy;
        flush     = fl;
        cnt_clr   = clr;
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0; in_data = '0; in_ctrl = '0;
        out_ready = 1'b0; flush = 1'b0; cnt_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Streaming 1..8 with the downstream always ready
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        for (int i = 1; i <= 8; i++) drive(1'b1, DW'(i), CWD'(i * 3), 1'b1, 1'b0, 1'b0);
        drive(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);

        // Back-pressure with A, B, C offered, then release
        drive(1'b1, 32'hA, 16'h00A1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 32'hB, 16'h00B2, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 32'hC, 16'h00C3, 1'b0, 1'b0, 1'b0);
        repeat (3) drive(1'b1, 32'hC, 16'h00C3, 1'b0, 1'b0, 1'b0);
        repeat (4) drive(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);

        // Flush with M and S full, an offered beat, and downstream stalled
        drive(1'b1, 32'h11, 16'h1111, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 32'h22, 16'h2222, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 32'h33, 16'h3333, 1'b0, 1'b1, 1'b0);
        repeat (2) drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);

        // Bubble control: all-ones ctrl consumed, then idle
        drive(1'b1, 32'h5A5A, 16'hFFFF, 1'b1, 1'b0, 1'b0);
        repeat (3) drive(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);

        // Counter saturation, then clear while the stall condition still holds
        drive(1'b1, 32'h77, 16'h0707, 1'b0, 1'b0, 1'b1);
        repeat (20) drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        repeat (2) drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 3) != 0), DW'($urandom), CWD'($urandom),
                  1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 30) == 0),
                  1'($urandom_range(0, 40) == 0));
        end

        // Asynchronous reset mid-cycle with both stages holding beats
        repeat (3) drive(1'b1, DW'($urandom), CWD'($urandom), 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #3 rst = 1'b1;
        in_valid = 1'b0;
        #1;
        chk("async_out_valid[0]", 64'(g_dut[0].out_valid), 64'(0));
        chk("async_out_ctrl[0]", 64'(g_dut[0].out_ctrl), 64'(0));
        chk("async_in_ready[0]", 64'(g_dut[0].in_ready), 64'(1));
        chk("async_stall[0]", 64'(g_dut[0].stall_cnt), 64'(0));
        chk("async_out_valid[1]", 64'(g_dut[1].out_valid), 64'(0));
        chk("async_out_ctrl[1]", 64'(g_dut[1].out_ctrl), 64'(0));
        chk("async_in_ready[1]", 64'(g_dut[1].in_ready), 64'(1));
        chk("async_stall[1]", 64'(g_dut[1].stall_cnt), 64'(0));
        @(posedge clk);
        #1 rst = 1'b0;

        repeat (30) drive(1'b1, DW'($urandom), CWD'($urandom), 1'($urandom_range(0, 1)), 1'b0, 1'b0);
        repeat (3) drive(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
